// File: rtl/hub_slot_master.sv
// Hub-side bus initiator: round-robin slot owner drives the hub memory bus, ack + read data two cycles later.
// Optional HUB_SLOT_SKIP_EN: an idle slot is handed to the next eligible port after the owner.
module hub_slot_master #(
  parameter int unsigned PORTS = 8,
  parameter int unsigned SW    = 3
) (
  input  logic                clk_cog,
  input  logic                nres,
  input  logic                ena_bus,
  input  logic [PORTS-1:0]    req,
  input  logic [PORTS-1:0]    req_w,
  input  logic [4*PORTS-1:0]  req_wb,
  input  logic [14*PORTS-1:0] req_a,
  input  logic [32*PORTS-1:0] req_d,
  output logic [PORTS-1:0]    ack,
  output logic [31:0]         rdata,
  output logic [SW-1:0]       slot,
  output logic                mem_w,
  output logic [3:0]          mem_wb,
  output logic [13:0]         mem_a,
  output logic [31:0]         mem_d,
  input  logic [31:0]         mem_q
);

  logic [SW-1:0]    slot_q, slot_d;
  logic [PORTS-1:0] busy_q, busy_d;
  logic             s1_vld_q, s1_vld_d;
  logic [SW-1:0]    s1_port_q, s1_port_d;
  logic [PORTS-1:0] ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             gnt_vld;
  logic [SW-1:0]    gnt_port;
`ifdef HUB_SLOT_SKIP_EN
  logic [SW-1:0]    cand;
`endif

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = slot_q;
`ifdef HUB_SLOT_SKIP_EN
    cand     = '0;
    // Scan starts at the owner itself, so the owner keeps priority in its own slot.
    for (int unsigned k = 0; k < PORTS; k++) begin
      cand = slot_q + SW'(k);
      if (!gnt_vld && req[cand] && !busy_q[cand]) begin
        gnt_vld  = 1'b1;
        gnt_port = cand;
      end
    end
`else
    gnt_vld = req[slot_q] && !busy_q[slot_q];
`endif
  end

  always_comb begin
    mem_w  = 1'b0;
    mem_wb = '0;
    mem_a  = '0;
    mem_d  = '0;
    if (nres && gnt_vld) begin
      mem_w  = req_w[gnt_port];
      mem_wb = req_wb[4*gnt_port +: 4];
      mem_a  = req_a[14*gnt_port +: 14];
      mem_d  = req_d[32*gnt_port +: 32];
    end
  end

  always_comb begin
    slot_d    = slot_q;
    // A port stays busy through its ack cycle so a still-held req is not served twice.
    busy_d    = busy_q & ~ack_q;
    s1_vld_d  = 1'b0;
    s1_port_d = s1_port_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    if (ena_bus) begin
      slot_d = slot_q + SW'(1);
      if (gnt_vld) begin
        busy_d[gnt_port] = 1'b1;
        s1_vld_d         = 1'b1;
        s1_port_d        = gnt_port;
      end
    end
    if (s1_vld_q) begin
      ack_d[s1_port_q] = 1'b1;
      rdata_d          = mem_q;
    end
  end

  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      slot_q    <= '0;
      busy_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_port_q <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
    end else begin
      slot_q    <= slot_d;
      busy_q    <= busy_d;
      s1_vld_q  <= s1_vld_d;
      s1_port_q <= s1_port_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign slot  = slot_q;

endmodule

// File: tb/tb_hub_slot_master.sv
// Bench for hub_slot_master: hub memory emulation, directed scenarios and random traffic checked
// against a slot/latency model; honours HUB_SLOT_SKIP_EN like the design.
module tb_hub_slot_master;
  localparam int PORTS = 8;
  localparam int SW    = 3;
  localparam int MEMW  = 16384;

  logic                clk_cog = 1'b0;
  logic                nres, ena_bus, mem_clr;
  logic [PORTS-1:0]    req;
  logic [PORTS-1:0]    req_w;
  logic [4*PORTS-1:0]  req_wb;
  logic [14*PORTS-1:0] req_a;
  logic [32*PORTS-1:0] req_d;
  logic [PORTS-1:0]    ack;
  logic [31:0]         rdata;
  logic [SW-1:0]       slot;
  logic                mem_w;
  logic [3:0]          mem_wb;
  logic [13:0]         mem_a;
  logic [31:0]         mem_d;
  logic [31:0]         mem_q;

  hub_slot_master #(.PORTS(PORTS), .SW(SW)) dut (
    .clk_cog(clk_cog), .nres(nres), .ena_bus(ena_bus),
    .req(req), .req_w(req_w), .req_wb(req_wb), .req_a(req_a), .req_d(req_d),
    .ack(ack), .rdata(rdata), .slot(slot),
    .mem_w(mem_w), .mem_wb(mem_wb), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk_cog = ~clk_cog;

  // Per-port request fields, packed onto the bus vectors.
  logic        w_f  [PORTS];
  logic [3:0]  wb_f [PORTS];
  logic [13:0] a_f  [PORTS];
  logic [31:0] d_f  [PORTS];

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      req_w[p]            = w_f[p];
      req_wb[4*p +: 4]    = wb_f[p];
      req_a[14*p +: 14]   = a_f[p];
      req_d[32*p +: 32]   = d_f[p];
    end
  end

  function automatic logic [31:0] init_val(input logic [13:0] a);
    return {2'b10, a, 2'b01, a} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Hub memory: samples on ena_bus edges, returns pre-write contents, ROM half ignores writes.
  logic [31:0] hub_wr  [MEMW];
  logic        wr_flag [MEMW];

  function automatic logic [31:0] hub_rd(input logic [13:0] a);
    return wr_flag[a] ? hub_wr[a] : init_val(a);
  endfunction

  always @(posedge clk_cog) begin
    if (mem_clr) begin
      for (int i = 0; i < MEMW; i++) wr_flag[i] <= 1'b0;
      mem_q <= '0;
    end else if (ena_bus) begin
      mem_q <= hub_rd(mem_a);
      if (mem_w && !mem_a[13]) begin
        hub_wr[mem_a]  <= merge(hub_rd(mem_a), mem_d, mem_wb);
        wr_flag[mem_a] <= 1'b1;
      end
    end
  end

  // Reference model state.
  typedef struct { int due; int port; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [MEMW];
  int          edge_n;
  int          m_slot;
  int          busy_until [PORTS];
  int          m_ack_cnt  [PORTS];
  logic [PORTS-1:0] cur_ack;
  logic [31:0] m_rdata;

  // Bench bookkeeping.
  int          n_cmp, n_mis;
  int          mode     [PORTS];
  int          ack_cnt  [PORTS];
  int          ack_edge [PORTS];
  logic [31:0] got_rd   [PORTS];
  logic [PORTS-1:0] ack_seen;
  int          ord[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int pick_owner(input int e);
    int s;
    s = m_slot;
    if (req[s] && e > busy_until[s]) return s;
`ifdef HUB_SLOT_SKIP_EN
    for (int k = 1; k < PORTS; k++) begin
      int p;
      p = (s + k) % PORTS;
      if (req[p] && e > busy_until[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic model_edge();
    int   g;
    exp_t ent;
    edge_n++;
    if (!nres) begin
      m_slot = 0;
      exp_q.delete();
      for (int p = 0; p < PORTS; p++) busy_until[p] = -10;
      cur_ack = '0;
      m_rdata = '0;
      return;
    end
    g = pick_owner(edge_n);
    if (ena_bus && g >= 0) begin
      ent.due  = edge_n + 1;
      ent.port = g;
      ent.data = ref_mem[a_f[g]];
      if (w_f[g] && !a_f[g][13]) ref_mem[a_f[g]] = merge(ref_mem[a_f[g]], d_f[g], wb_f[g]);
      exp_q.push_back(ent);
      busy_until[g] = edge_n + 2;
    end
    if (ena_bus) m_slot = (m_slot + 1) % PORTS;
    cur_ack = '0;
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      cur_ack[exp_q[0].port] = 1'b1;
      m_rdata = exp_q[0].data;
      m_ack_cnt[exp_q[0].port]++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_mem();
    int g;
    logic ew; logic [3:0] ewb; logic [13:0] ea; logic [31:0] ed;
    g = nres ? pick_owner(edge_n + 1) : -1;
    ew = 1'b0; ewb = '0; ea = '0; ed = '0;
    if (g >= 0) begin ew = w_f[g]; ewb = wb_f[g]; ea = a_f[g]; ed = d_f[g]; end
    check("mem_w",  32'(mem_w),  32'(ew));
    check("mem_wb", 32'(mem_wb), 32'(ewb));
    check("mem_a",  32'(mem_a),  32'(ea));
    check("mem_d",  mem_d,       ed);
  endtask

  task automatic check_outs();
    check("ack",      32'(ack),   32'(cur_ack));
    check("rdata",    rdata,      m_rdata);
    check("slot",     32'(slot),  32'(m_slot));
    check("ack_1hot", 32'($countones(ack) <= 1), 32'd1);
    ack_seen = ack;
    for (int p = 0; p < PORTS; p++) if (ack[p]) begin
      ack_cnt[p]++;
      got_rd[p]   = rdata;
      ack_edge[p] = edge_n;
      ord.push_back(p);
    end
  endtask

  task automatic rand_fields(input int p);
    w_f[p]  = 1'($urandom_range(0, 1));
    wb_f[p] = 4'($urandom);
    a_f[p]  = 14'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 14'h2000 : 14'h0000);
    d_f[p]  = $urandom;
  endtask

  // Requesters react to the ack they sampled at the edge just passed.
  task automatic drive_update();
    for (int p = 0; p < PORTS; p++) begin
      if (ack_seen[p]) begin
        if (mode[p] == 0) req[p] = 1'b0;
        else if (mode[p] == 2) begin
          if ($urandom_range(0, 1) == 1) req[p] = 1'b0;
          else rand_fields(p);
        end
      end else if (mode[p] == 2 && !req[p] && $urandom_range(0, 3) == 0) begin
        rand_fields(p);
        req[p] = 1'b1;
      end
    end
  endtask

  task automatic step();
    #1 check_mem();
    @(posedge clk_cog);
    model_edge();
    #1;
    drive_update();
    check_outs();
  endtask

  // em: 0 toggle, 1 held high, 2 random
  task automatic run_one(input int em);
    case (em)
      0:       ena_bus = ~ena_bus;
      1:       ena_bus = 1'b1;
      default: ena_bus = ($urandom_range(0, 9) < 7);
    endcase
    step();
  endtask

  task automatic set_req(input int p, input logic w, input logic [3:0] wb,
                         input logic [13:0] a, input logic [31:0] d);
    w_f[p] = w; wb_f[p] = wb; a_f[p] = a; d_f[p] = d;
    req[p] = 1'b1;
  endtask

  task automatic wait_done(input int p, input int em, input int lim);
    for (int i = 0; i < lim && req[p]; i++) run_one(em);
    check($sformatf("done_p%0d", p), 32'(req[p]), 32'd0);
  endtask

  task automatic do_reset(input int n);
    nres = 1'b0;
    for (int i = 0; i < n; i++) run_one(1);
    nres = 1'b1;
  endtask

  initial begin
    int cnt, s0, lat;
    n_cmp = 0; n_mis = 0; edge_n = 0; m_slot = 0; m_rdata = '0; cur_ack = '0;
    ack_seen = '0;
    for (int i = 0; i < MEMW; i++) ref_mem[i] = init_val(14'(i));
    for (int p = 0; p < PORTS; p++) begin
      busy_until[p] = -10; m_ack_cnt[p] = 0; ack_cnt[p] = 0; ack_edge[p] = 0;
      got_rd[p] = '0; mode[p] = 0;
      w_f[p] = 1'b0; wb_f[p] = '0; a_f[p] = '0; d_f[p] = '0;
    end

    // Reset with every port requesting.
    mem_clr = 1'b1; nres = 1'b0; ena_bus = 1'b1; req = '1;
    for (int i = 0; i < 3; i++) run_one(1);
    mem_clr = 1'b0; nres = 1'b1; req = '0;
    run_one(1);
    check("slot_after_rst", 32'(slot), 32'd1);

    // Port 3 write then read back.
    set_req(3, 1'b1, 4'hF, 14'h0010, 32'hDEADBEEF);
    wait_done(3, 0, 60);
    check("p3_wr_acks", 32'(ack_cnt[3]), 32'd1);
    set_req(3, 1'b0, 4'h0, 14'h0010, 32'h0);
    wait_done(3, 0, 60);
    check("p3_rd", got_rd[3], 32'hDEADBEEF);

    // Byte-enable merge on port 0.
    set_req(0, 1'b1, 4'hF, 14'h0020, 32'h11223344);
    wait_done(0, 0, 60);
    set_req(0, 1'b1, 4'h2, 14'h0020, 32'h0000AA00);
    wait_done(0, 0, 60);
    check("p0_wr_pre", got_rd[0], 32'h11223344);
    set_req(0, 1'b0, 4'h0, 14'h0020, 32'h0);
    wait_done(0, 0, 60);
    check("p0_bytes", got_rd[0], 32'h1122AA44);

    // All ports at once, from slot 0.
    do_reset(2);
    ord.delete();
    for (int p = 0; p < PORTS; p++) set_req(p, 1'b0, 4'h0, 14'(32'h100 + p), 32'h0);
    for (int i = 0; i < 200 && req != '0; i++) run_one(0);
    check("ord_n", 32'(ord.size()), 32'd8);
    for (int i = 0; i < PORTS; i++) begin
      if (i < ord.size()) check($sformatf("ord%0d", i), 32'(ord[i]), 32'(i));
      check($sformatf("all_rd%0d", i), got_rd[i], init_val(14'(32'h100 + i)));
    end

    // Port 5 holds req with ena_bus continuously high.
    cnt = ack_cnt[5];
    mode[5] = 1;
    set_req(5, 1'b0, 4'h0, 14'h0055, 32'h0);
    for (int i = 0; i < 40; i++) run_one(1);
    check("p5_cnt", 32'(ack_cnt[5]), 32'(m_ack_cnt[5]));
    check("p5_some", 32'(ack_cnt[5] - cnt >= 4), 32'd1);
    mode[5] = 0;
    wait_done(5, 1, 40);

    // Reset between service edge and ack of port 2.
    do_reset(2);
    set_req(2, 1'b0, 4'h0, 14'h0030, 32'h0);
    for (int i = 0; i < 20; i++) begin
      run_one(1);
      if (busy_until[2] == edge_n + 2) break;
    end
    check("p2_served", 32'(busy_until[2]), 32'(edge_n + 2));
    nres = 1'b0;
    run_one(1);
    nres = 1'b1;
    req[2] = 1'b0;
    cnt = ack_cnt[2];
    for (int i = 0; i < 12; i++) run_one(1);
    check("p2_dropped", 32'(ack_cnt[2]), 32'(cnt));
    set_req(2, 1'b0, 4'h0, 14'h0030, 32'h0);
    wait_done(2, 1, 40);
    check("p2_again", 32'(ack_cnt[2]), 32'(cnt + 1));
    check("p2_rd", got_rd[2], init_val(14'h0030));

    // Lone requester on port 6 while slot = 1.
    do_reset(2);
    run_one(1);
    set_req(6, 1'b0, 4'h0, 14'h0066, 32'h0);
    s0 = edge_n;
    wait_done(6, 1, 30);
`ifdef HUB_SLOT_SKIP_EN
    lat = 2;
`else
    lat = 7;
`endif
    check("p6_lat", 32'(ack_edge[6] - s0), 32'(lat));

    // Random traffic.
    do_reset(2);
    for (int p = 0; p < PORTS; p++) mode[p] = 2;
    for (int i = 0; i < 1500; i++) run_one(((i / 100) % 3 == 1) ? 1 : 2);
    for (int p = 0; p < PORTS; p++) check($sformatf("rnd_cnt%0d", p), 32'(ack_cnt[p]) - 32'(ack_cnt[p]) + 32'(m_ack_cnt[p] > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
